// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: mul/div op encodings, HI/LO funct codes
// and the multiply/divide sequencer state type.
package mips_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared shift/add datapath: radix-2 shift-add multiply or restoring divide,
// one iteration per asserted step, operating on unsigned magnitudes.
module muldiv_iter_core #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic           is_div,
  input  logic [W-1:0]   opa,
  input  logic [W-1:0]   opb,
  output logic [2*W-1:0] prod,
  output logic [W-1:0]   quot,
  output logic [W-1:0]   rem
);

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide: acc[W-1:0] shifts dividend bits out and quotient bits in.
  logic [2*W-1:0] acc;
  logic [W-1:0]   rem_q;
  logic [W-1:0]   opnd;
  logic           div_mode;

  logic [W:0] mul_sum;
  logic [W:0] div_shift;
  logic [W:0] div_trial;

  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    div_shift = {rem_q, acc[W-1]};
    div_trial = div_shift - {1'b0, opnd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      rem_q    <= '0;
      opnd     <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      acc      <= {{W{1'b0}}, (is_div ? opa : opb)};
      opnd     <= is_div ? opb : opa;
      rem_q    <= '0;
      div_mode <= is_div;
    end else if (step) begin
      if (div_mode) begin
        // A failed trial leaves a shifted remainder below the divisor, so its top bit is zero.
        if (!div_trial[W]) begin
          rem_q         <= div_trial[W-1:0];
          acc[W-1:0]    <= {acc[W-2:0], 1'b1};
        end else begin
          rem_q         <= div_shift[W-1:0];
          acc[W-1:0]    <= {acc[W-2:0], 1'b0};
        end
      end else begin
        acc <= {mul_sum, acc[W-1:1]};
      end
    end
  end

  assign prod = acc;
  assign quot = acc[W-1:0];
  assign rem  = rem_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with architectural HI/LO and core stall.
// Handshake: start/mf_req/mt_* are levels re-presented by the core while stall=1; done pulses with new HI/LO.
module muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   rs_data,
  input  logic [W-1:0]   rt_data,
  input  logic           mf_req,
  input  logic           mt_hi,
  input  logic           mt_lo,
  output logic [W-1:0]   hi,
  output logic [W-1:0]   lo,
  output logic           busy,
  output logic           done,
  output logic           stall,
  output md_state_t      fsm_state
);

  md_state_t        state;
  md_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             div_q;
  logic             neg_a;
  logic             neg_b;
  logic             dz_q;
  logic [W-1:0]     rs_raw;

  logic             load;
  logic             step;
  logic             sgn;
  logic [W-1:0]     abs_a;
  logic [W-1:0]     abs_b;
  logic [2*W-1:0]   prod;
  logic [W-1:0]     quot;
  logic [W-1:0]     rem;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     quot_fix;
  logic [W-1:0]     rem_fix;

  always_comb begin
    sgn   = op_is_signed(op);
    abs_a = (sgn && rs_data[W-1]) ? -rs_data : rs_data;
    abs_b = (sgn && rt_data[W-1]) ? -rt_data : rt_data;
  end

  muldiv_iter_core #(.W(W)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .is_div (op_is_div(op)),
    .opa    (abs_a),
    .opb    (abs_b),
    .prod   (prod),
    .quot   (quot),
    .rem    (rem)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = (op_is_div(op) && rt_data == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == '0) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Remainder takes the dividend's sign; product and quotient follow the xor of signs.
  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? -prod : prod;
    quot_fix = (neg_a ^ neg_b) ? -quot : quot;
    rem_fix  = neg_a ? -rem : rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      div_q  <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      dz_q   <= 1'b0;
      rs_raw <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= CNT_W'(W - 1);
            div_q  <= op_is_div(op);
            neg_a  <= sgn & rs_data[W-1];
            neg_b  <= sgn & rt_data[W-1];
            dz_q   <= op_is_div(op) && (rt_data == '0);
            rs_raw <= rs_data;
          end else begin
            if (mt_hi) hi <= rs_data;
            if (mt_lo) lo <= rs_data;
          end
        end
        CALC: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          done <= 1'b1;
          if (dz_q) begin
            hi <= rs_raw;
            lo <= '1;
          end else if (div_q) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[2*W-1:W];
            lo <= prod_fix[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign stall     = busy & (start | mf_req | mt_hi | mt_lo);
  assign fsm_state = state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO and completion cycle are queued at issue
// and popped by a monitor whenever done pulses.
module tb_muldiv_sequencer;
  import mips_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         mf_req;
  logic         mt_hi;
  logic         mt_lo;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         stall;
  md_state_t    fsm_state;

  int     vectors = 0;
  int     miscompares = 0;
  longint cyc = 0;

  logic [2*W-1:0] exp_q[$];
  longint         due_q[$];

  muldiv_sequencer #(.W(W), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .mf_req    (mf_req),
    .mt_hi     (mt_hi),
    .mt_lo     (mt_lo),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .fsm_state (fsm_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference model: MIPS HI/LO semantics with plain wide arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint     sa;
    longint     sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (o)
      MD_MULT:  r = 64'(sa * sb);
      MD_MULTU: r = {32'b0, a} * {32'b0, b};
      MD_DIV: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          r[31:0]  = 32'(sa / sb);
          r[63:32] = 32'(sa % sb);
        end
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          r[31:0]  = a / b;
          r[63:32] = a % b;
        end
      end
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with no operation outstanding", cyc);
      end else begin
        logic [63:0] e;
        longint      d;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("result_hilo", {hi, lo}, e);
        check("done_cycle", 64'(cyc), 64'(d));
      end
    end
  end

  // Driver tasks
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic with_mf);
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    exp_q.push_back(model(o, a, b));
    due_q.push_back(cyc + 1 + ((o[1] && b == 0) ? 1 : W + 1));
    @(negedge clk);
    start   = 1'b0;
    mf_req  = with_mf;
    op      = 2'($urandom);
    rs_data = $urandom;
    rt_data = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(o, a, b, 1'b0);
    wait_idle();
  endtask

  initial begin
    logic [63:0] e;
    int          n;
    logic [1:0]  ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst_n = 1'b0; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
    mf_req = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
    #1;
    check("reset_hilo", {hi, lo}, 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_done", 64'(done), 64'h0);
    check("reset_stall", 64'(stall), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with independently known answers
    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult_neg3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(MD_DIVU, 32'd100, 32'd7);
    check("divu_100_7", {hi, lo}, 64'h0000_0002_0000_000E);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(MD_DIV, 32'h1234_5678, 32'd0);
    check("div_by_zero", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    run_op(MD_DIVU, 32'hDEAD_BEEF, 32'd0);
    check("divu_by_zero", {hi, lo}, 64'hDEAD_BEEF_FFFF_FFFF);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // MFLO presented one cycle after MULT stalls until done
    e = model(MD_MULT, 32'hFFFF_FFF9, 32'd6);
    issue(MD_MULT, 32'hFFFF_FFF9, 32'd6, 1'b1);
    #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("mf_stall_cycles", 64'(n), 64'd33);
    check("mf_done_on_release", 64'(done), 64'd1);
    check("mf_lo_on_release", 64'(lo), 64'(e[31:0]));
    @(negedge clk);
    mf_req = 1'b0;

    // MTHI in IDLE lands next edge without stall
    @(negedge clk);
    mt_hi   = 1'b1;
    rs_data = 32'hAABB_CCDD;
    #1;
    check("mthi_idle_stall", 64'(stall), 64'd0);
    @(negedge clk);
    mt_hi = 1'b0;
    check("mthi_idle_hi", 64'(hi), 64'h0000_0000_AABB_CCDD);

    // MTLO while busy stalls and lands after done
    ra = $urandom; rb = $urandom_range(1, 1000);
    e  = model(MD_DIVU, ra, rb);
    issue(MD_DIVU, ra, rb, 1'b0);
    mt_lo   = 1'b1;
    rs_data = 32'h5566_7788;
    #1;
    check("mtlo_busy_stall", 64'(stall), 64'd1);
    wait_idle();
    check("mtlo_pre_lo", 64'(lo), 64'(e[31:0]));
    @(negedge clk);
    mt_lo = 1'b0;
    check("mtlo_post_lo", 64'(lo), 64'h0000_0000_5566_7788);
    check("mtlo_post_hi", 64'(hi), 64'(e[63:32]));

    // start while busy is ignored
    issue(MD_MULTU, 32'd1234, 32'd5678, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1; op = MD_DIV; rs_data = $urandom; rt_data = $urandom;
    #1;
    check("start_busy_stall", 64'(stall), 64'd1);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Async reset in CALC at cnt=10
    issue(MD_MULT, 32'h0123_4567, 32'h89AB_CDEF, 1'b0);
    repeat (21) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    due_q.delete();
    #1;
    check("midrst_hilo", {hi, lo}, 64'h0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_stall", 64'(stall), 64'd0);
    check("midrst_state", 64'(fsm_state), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    run_op(MD_MULTU, 32'd3, 32'd4);
    check("post_rst_multu", {hi, lo}, 64'h0000_0000_0000_000C);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = -($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
